lsu_arbiter: RTL and testbench
==============================

// Module: lsu_arbiter
// PURPOSE
//  Shares the single data-memory/IO port (lsu) between two requesters: the
//  rv32i core (port C) and the debug/program-load master (port D). Per-cycle
//  arbitration, round-robin by default; D may lock the port for bursts.
//  Drives o_core_stall, which the core maps onto pc_en.
//  Tags pipelined read data so each read returns only to its issuer.
// PARAMETERS
//  ADDR_W    32  address width, both ports and memory
//  RD_LAT    1   memory read latency in cycles, legal 1..4
//  WAIT_MAX  8   starvation bound: max consecutive cycles C waits, legal 1..255
// PORTS
//  i_clk          in   1       clock, rising edge
//  i_rst          in   1       synchronous reset, active-high
//  i_c_req        in   1       core access request, held until granted
//  i_c_we         in   1       core write (1) / read (0)
//  i_c_addr       in   ADDR_W  core address
//  i_c_wdata      in   32      core store data
//  i_c_strb       in   4       core byte strobes
//  o_c_gnt        out  1       core request accepted this cycle
//  o_c_rvld       out  1       core read data valid
//  o_c_rdata      out  32      core read data
//  o_core_stall   out  1       i_c_req & ~o_c_gnt (combinational)
//  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_strb, o_d_gnt, o_d_rvld, o_d_rdata
//                 -    -       debug port, same widths and meaning as C
//  i_d_lock       in   1       debug requests port retention after its grant
//  o_mem_vld      out  1       access issued to memory this cycle
//  o_mem_we       out  1       issued access is a write
//  o_mem_addr     out  ADDR_W  issued address
//  o_mem_wdata    out  32      issued store data
//  o_mem_strb     out  4       issued strobes; 4'b0 when o_mem_vld=0
//  i_mem_rdata    in   32      read data, valid RD_LAT cycles after issue
// BEHAVIOUR
//  - Arbitration is combinational each cycle; at most one gnt per cycle.
//    Granted port's we/addr/wdata/strb pass to o_mem_*; o_mem_vld = gnt_c|gnt_d.
//    No grant: o_mem_vld=0, o_mem_we=0, o_mem_strb=0, addr/wdata=0.
//  - FSM (registered): RR (round-robin) and LOCK.
//    RR: only one req -> grant it. Both -> grant the port not granted last
//      (last_gnt register, reset = D, so C wins first contention).
//      Enter LOCK when D granted and i_d_lock=1 in the same cycle.
//    LOCK: D has priority whenever i_d_req=1; C granted only if i_d_req=0.
//      Exit to RR when i_d_lock=0 (sampled each cycle), or on forced grant.
//  - Starvation: wait_cnt (8b) increments each cycle i_c_req & ~o_c_gnt,
//    clears when o_c_gnt=1 or i_c_req=0. When wait_cnt==WAIT_MAX, C is
//    granted unconditionally that cycle; FSM returns to RR, last_gnt=C.
//  - Read return: RD_LAT-deep shift register of {vld, owner}; pushed on each
//    granted read (writes push vld=0). At tail: o_x_rvld=1 for owner only;
//    o_x_rdata = i_mem_rdata when own rvld, else 32'h0.
//  - Latency: gnt same cycle as req; read data RD_LAT cycles after gnt.
//    Back-to-back reads from either port fully pipelined, one per cycle.
//  - Requester must hold req/we/addr/wdata/strb stable until gnt; a request
//    dropped before gnt is simply not served (no error).
//  - Reset: FSM=RR, last_gnt=D, wait_cnt=0, return pipe cleared; all outputs 0
//    except o_core_stall, which follows i_c_req. Reset mid-read discards
//    in-flight responses; no rvld pulses after reset for them.
//  - Simultaneous grant-to-D with i_d_lock=1 and wait_cnt==WAIT_MAX cannot
//    occur: forced C grant takes precedence, LOCK not entered.
// TESTING
//  1 C only, read addr 0x100, RD_LAT=1 -> c_gnt same cycle, c_rvld next cycle
//    with mem data 0xDEADBEEF; d_rvld stays 0; stall 0.
//  2 C and D both req continuously, no lock -> grants alternate C,D,C,D;
//    o_core_stall high exactly on D cycles.
//  3 D locked burst of 20 writes, C req throughout, WAIT_MAX=8 -> C stalls 8
//    cycles, forced grant on 9th, FSM back to RR, then alternation resumes.
//  4 RD_LAT=3, reads issued C,D,C back-to-back -> rvld pulses on C,D,C in
//    order, 3 cycles after each gnt, correct rdata per port.
//  5 C write strb 4'b0011 -> o_mem_we=1, o_mem_strb=4'b0011, no rvld on
//    either port afterwards.
//  6 i_rst asserted one cycle after a granted read (RD_LAT=2) -> no rvld
//    ever for that read; all outputs 0 during reset; first contention after
//    reset grants C.

Source files
------------

// File: rtl/lsu_arbiter.sv
// Shares the single data-memory/IO port between the core (C) and the debug master (D).
// Per-cycle round-robin with a D burst lock, a C starvation bound and tagged read return.
module lsu_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int WAIT_MAX = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_c_req,
    input  logic              i_c_we,
    input  logic [ADDR_W-1:0] i_c_addr,
    input  logic [31:0]       i_c_wdata,
    input  logic [3:0]        i_c_strb,
    output logic              o_c_gnt,
    output logic              o_c_rvld,
    output logic [31:0]       o_c_rdata,
    output logic              o_core_stall,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [31:0]       i_d_wdata,
    input  logic [3:0]        i_d_strb,
    input  logic              i_d_lock,
    output logic              o_d_gnt,
    output logic              o_d_rvld,
    output logic [31:0]       o_d_rdata,
    output logic              o_mem_vld,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_strb,
    input  logic [31:0]       i_mem_rdata
);

    typedef enum logic {
        RR,
        LOCK
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              last_d;
    logic              last_d_nx;
    logic [7:0]        wait_cnt;
    logic              force_c;
    logic              gnt_c;
    logic              gnt_d;
    logic              rd_issue;
    logic              tail_vld;
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_own;

    assign force_c = i_c_req && (wait_cnt == 8'(WAIT_MAX));

    always_comb begin
        gnt_c     = 1'b0;
        gnt_d     = 1'b0;
        state_nx  = state;
        last_d_nx = last_d;
        if (i_rst) begin
            gnt_c = 1'b0;
        end else if (force_c) begin
            gnt_c = 1'b1;
        end else if (state == LOCK) begin
            if (i_d_req) begin
                gnt_d = 1'b1;
            end else begin
                gnt_c = i_c_req;
            end
        end else if (i_c_req && i_d_req) begin
            gnt_c = last_d;
            gnt_d = !last_d;
        end else begin
            gnt_c = i_c_req;
            gnt_d = i_d_req;
        end

        if (gnt_c) last_d_nx = 1'b0;
        if (gnt_d) last_d_nx = 1'b1;

        // A forced C grant always breaks a D lock
        if (force_c) begin
            state_nx = RR;
        end else begin
            case (state)
                RR:      if (gnt_d && i_d_lock) state_nx = LOCK;
                LOCK:    if (!i_d_lock) state_nx = RR;
                default: state_nx = RR;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= RR;
            last_d <= 1'b1;
        end else begin
            state  <= state_nx;
            last_d <= last_d_nx;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cnt <= 8'd0;
        end else if (i_c_req && !gnt_c) begin
            if (wait_cnt != 8'hff) wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    assign rd_issue = (gnt_c && !i_c_we) || (gnt_d && !i_d_we);

    // Owner bit: 1 = debug port
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pipe_vld <= '0;
            pipe_own <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_own[i] <= pipe_own[i-1];
            end
            pipe_vld[0] <= rd_issue;
            pipe_own[0] <= gnt_d;
        end
    end

    assign tail_vld  = pipe_vld[RD_LAT-1] && !i_rst;
    assign o_c_rvld  = tail_vld && !pipe_own[RD_LAT-1];
    assign o_d_rvld  = tail_vld && pipe_own[RD_LAT-1];
    assign o_c_rdata = o_c_rvld ? i_mem_rdata : 32'h0;
    assign o_d_rdata = o_d_rvld ? i_mem_rdata : 32'h0;

    assign o_c_gnt      = gnt_c;
    assign o_d_gnt      = gnt_d;
    assign o_core_stall = i_c_req && !gnt_c;
    assign o_mem_vld    = gnt_c || gnt_d;

    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = 32'h0;
        o_mem_strb  = 4'h0;
        if (gnt_c) begin
            o_mem_we    = i_c_we;
            o_mem_addr  = i_c_addr;
            o_mem_wdata = i_c_wdata;
            o_mem_strb  = i_c_strb;
        end else if (gnt_d) begin
            o_mem_we    = i_d_we;
            o_mem_addr  = i_d_addr;
            o_mem_wdata = i_d_wdata;
            o_mem_strb  = i_d_strb;
        end
    end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter; three instances with read latency 1, 2 and 3
// share all inputs so latency-dependent scenarios run side by side.
module tb_lsu_arbiter;

    logic        clk;
    logic        rst;
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_strb;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_strb;
    logic        d_lock;

    logic        c_gnt    [3];
    logic        c_rvld   [3];
    logic [31:0] c_rdata  [3];
    logic        stall    [3];
    logic        d_gnt    [3];
    logic        d_rvld   [3];
    logic [31:0] d_rdata  [3];
    logic        mem_vld  [3];
    logic        mem_we   [3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata[3];
    logic [3:0]  mem_strb [3];
    logic [31:0] mem_rdata[3];
    logic [31:0] hist     [3];

    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        lsu_arbiter #(.ADDR_W(32), .RD_LAT(g + 1), .WAIT_MAX(8)) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_c_req     (c_req),
            .i_c_we      (c_we),
            .i_c_addr    (c_addr),
            .i_c_wdata   (c_wdata),
            .i_c_strb    (c_strb),
            .o_c_gnt     (c_gnt[g]),
            .o_c_rvld    (c_rvld[g]),
            .o_c_rdata   (c_rdata[g]),
            .o_core_stall(stall[g]),
            .i_d_req     (d_req),
            .i_d_we      (d_we),
            .i_d_addr    (d_addr),
            .i_d_wdata   (d_wdata),
            .i_d_strb    (d_strb),
            .i_d_lock    (d_lock),
            .o_d_gnt     (d_gnt[g]),
            .o_d_rvld    (d_rvld[g]),
            .o_d_rdata   (d_rdata[g]),
            .o_mem_vld   (mem_vld[g]),
            .o_mem_we    (mem_we[g]),
            .o_mem_addr  (mem_addr[g]),
            .o_mem_wdata (mem_wdata[g]),
            .o_mem_strb  (mem_strb[g]),
            .i_mem_rdata (mem_rdata[g])
        );
        assign mem_rdata[g] = 32'hDEADBEEF + hist[g] - 32'h100;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data for an address appears g+1 cycles after its issue
    always @(posedge clk) begin
        hist[2] <= hist[1];
        hist[1] <= hist[0];
        hist[0] <= mem_addr[0];
    end

    task automatic idle();
        c_req   = 1'b0;
        c_we    = 1'b0;
        c_addr  = 32'h0;
        c_wdata = 32'h0;
        c_strb  = 4'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        d_strb  = 4'h0;
        d_lock  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst   = 1'b1;
        idle();
        c_req = 1'b1;
        d_req = 1'b1;
        #1;
        tests++;
        if (c_gnt[0] !== 1'b0 || d_gnt[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_gnt got c=%b d=%b want 0 0", c_gnt[0], d_gnt[0]);
        end
        tests++;
        if (mem_vld[0] !== 1'b0 || mem_strb[0] !== 4'h0) begin
            fails++;
            $display("FAIL reset_mem got vld=%b strb=%h want 0 0", mem_vld[0], mem_strb[0]);
        end
        tests++;
        if (stall[0] !== 1'b1) begin
            fails++;
            $display("FAIL reset_stall got %b want 1", stall[0]);
        end
        tests++;
        if (c_rvld[2] !== 1'b0 || d_rvld[2] !== 1'b0) begin
            fails++;
            $display("FAIL reset_rvld got c=%b d=%b want 0 0", c_rvld[2], d_rvld[2]);
        end
        @(negedge clk);
        idle();
        rst = 1'b0;
    endtask

    task automatic test_c_read();
        @(negedge clk);
        idle();
        c_req  = 1'b1;
        c_addr = 32'h100;
        #1;
        tests++;
        if (c_gnt[0] !== 1'b1 || d_gnt[0] !== 1'b0 || stall[0] !== 1'b0) begin
            fails++;
            $display("FAIL c_read_gnt got c=%b d=%b stall=%b want 1 0 0",
                     c_gnt[0], d_gnt[0], stall[0]);
        end
        tests++;
        if (mem_vld[0] !== 1'b1 || mem_we[0] !== 1'b0 || mem_addr[0] !== 32'h100) begin
            fails++;
            $display("FAIL c_read_mem got vld=%b we=%b addr=%h want 1 0 00000100",
                     mem_vld[0], mem_we[0], mem_addr[0]);
        end
        @(negedge clk);
        idle();
        #1;
        tests++;
        if (c_rvld[0] !== 1'b1 || c_rdata[0] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL c_read_data got rvld=%b data=%h want 1 deadbeef",
                     c_rvld[0], c_rdata[0]);
        end
        tests++;
        if (d_rvld[0] !== 1'b0 || d_rdata[0] !== 32'h0 || stall[0] !== 1'b0) begin
            fails++;
            $display("FAIL c_read_d_quiet got rvld=%b data=%h stall=%b want 0 0 0",
                     d_rvld[0], d_rdata[0], stall[0]);
        end
    endtask

    task automatic test_alternate();
        @(negedge clk);
        idle();
        d_req = 1'b1;
        d_we  = 1'b1;
        d_strb = 4'hf;
        #1;
        tests++;
        if (d_gnt[0] !== 1'b1) begin
            fails++;
            $display("FAIL alt_d_only got %b want 1", d_gnt[0]);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            c_req  = 1'b1;
            c_we   = 1'b1;
            c_addr = 32'h20 + 32'(i);
            c_strb = 4'hf;
            d_addr = 32'h60 + 32'(i);
            #1;
            tests++;
            if (c_gnt[0] !== (i % 2 == 0) || d_gnt[0] !== (i % 2 == 1) ||
                stall[0] !== (i % 2 == 1)) begin
                fails++;
                $display("FAIL alt_%0d got c=%b d=%b stall=%b want %b %b %b", i,
                         c_gnt[0], d_gnt[0], stall[0], i % 2 == 0, i % 2 == 1, i % 2 == 1);
            end
        end
    endtask

    task automatic test_lock_starve();
        logic exp_c;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            idle();
            c_req   = 1'b1;
            c_we    = 1'b1;
            c_strb  = 4'hf;
            c_addr  = 32'h80 + 32'(i * 4);
            d_req   = 1'b1;
            d_we    = 1'b1;
            d_strb  = 4'hf;
            d_addr  = 32'h400 + 32'(i * 4);
            d_wdata = 32'(i);
            d_lock  = (i <= 9);
            exp_c   = (i == 0) || (i == 9) || (i >= 10 && i % 2 == 1);
            #1;
            tests++;
            if (c_gnt[0] !== exp_c || d_gnt[0] !== !exp_c || stall[0] !== !exp_c) begin
                fails++;
                $display("FAIL lock_%0d got c=%b d=%b stall=%b want %b %b %b", i,
                         c_gnt[0], d_gnt[0], stall[0], exp_c, !exp_c, !exp_c);
            end
            if (i == 9) begin
                tests++;
                if (mem_addr[0] !== 32'hA4) begin
                    fails++;
                    $display("FAIL lock_forced_addr got %h want 000000a4", mem_addr[0]);
                end
            end
        end
    endtask

    task automatic test_pipelined_reads();
        logic        ec [7];
        logic        ed [7];
        logic [31:0] dc [7];
        logic [31:0] dd [7];
        for (int w = 0; w < 7; w++) begin
            ec[w] = 1'b0;
            ed[w] = 1'b0;
            dc[w] = 32'h0;
            dd[w] = 32'h0;
        end
        ec[3] = 1'b1; dc[3] = 32'hDEADBFEF;
        ed[4] = 1'b1; dd[4] = 32'hDEADC0EF;
        ec[5] = 1'b1; dc[5] = 32'hDEADBFF3;
        for (int w = 0; w < 7; w++) begin
            @(negedge clk);
            idle();
            if (w == 0) begin c_req = 1'b1; c_addr = 32'h200; end
            if (w == 1) begin d_req = 1'b1; d_addr = 32'h300; end
            if (w == 2) begin c_req = 1'b1; c_addr = 32'h204; end
            #1;
            if (w < 3) begin
                tests++;
                if (mem_vld[2] !== 1'b1 || c_gnt[2] !== (w != 1)) begin
                    fails++;
                    $display("FAIL pipe_gnt_%0d got vld=%b c=%b", w, mem_vld[2], c_gnt[2]);
                end
            end
            tests++;
            if (c_rvld[2] !== ec[w] || d_rvld[2] !== ed[w] ||
                c_rdata[2] !== dc[w] || d_rdata[2] !== dd[w]) begin
                fails++;
                $display("FAIL pipe_ret_%0d got c=%b/%h d=%b/%h want %b/%h %b/%h", w,
                         c_rvld[2], c_rdata[2], d_rvld[2], d_rdata[2],
                         ec[w], dc[w], ed[w], dd[w]);
            end
        end
    endtask

    task automatic test_write_strb();
        @(negedge clk);
        idle();
        c_req   = 1'b1;
        c_we    = 1'b1;
        c_addr  = 32'h40;
        c_wdata = 32'h12345678;
        c_strb  = 4'b0011;
        #1;
        tests++;
        if (c_gnt[0] !== 1'b1 || mem_we[0] !== 1'b1 || mem_strb[0] !== 4'b0011 ||
            mem_wdata[0] !== 32'h12345678) begin
            fails++;
            $display("FAIL wr_issue got gnt=%b we=%b strb=%b wdata=%h want 1 1 0011 12345678",
                     c_gnt[0], mem_we[0], mem_strb[0], mem_wdata[0]);
        end
        for (int w = 1; w < 5; w++) begin
            @(negedge clk);
            idle();
            #1;
            tests++;
            if (c_rvld[0] | c_rvld[1] | c_rvld[2] | d_rvld[0] | d_rvld[1] | d_rvld[2] |
                mem_vld[0] | (mem_strb[0] != 4'h0)) begin
                fails++;
                $display("FAIL wr_quiet_%0d got rvld c=%b%b%b d=%b%b%b vld=%b strb=%b", w,
                         c_rvld[0], c_rvld[1], c_rvld[2], d_rvld[0], d_rvld[1], d_rvld[2],
                         mem_vld[0], mem_strb[0]);
            end
        end
    endtask

    task automatic test_reset_midread();
        @(negedge clk);
        idle();
        c_req  = 1'b1;
        c_addr = 32'h180;
        #1;
        tests++;
        if (c_gnt[1] !== 1'b1) begin
            fails++;
            $display("FAIL rst_rd_gnt got %b want 1", c_gnt[1]);
        end
        @(negedge clk);
        idle();
        rst   = 1'b1;
        d_req = 1'b1;
        #1;
        tests++;
        if (c_gnt[1] | d_gnt[1] | mem_vld[1] | stall[1] | c_rvld[0] | c_rvld[1] |
            d_rvld[1] | (mem_addr[1] != 32'h0) | (c_rdata[0] != 32'h0)) begin
            fails++;
            $display("FAIL rst_outputs got gnt=%b%b vld=%b stall=%b rvld=%b%b%b addr=%h",
                     c_gnt[1], d_gnt[1], mem_vld[1], stall[1], c_rvld[0], c_rvld[1],
                     d_rvld[1], mem_addr[1]);
        end
        for (int w = 2; w < 5; w++) begin
            @(negedge clk);
            idle();
            rst = 1'b0;
            #1;
            tests++;
            if (c_rvld[1] | d_rvld[1] | c_rvld[2] | d_rvld[2]) begin
                fails++;
                $display("FAIL rst_no_rvld_%0d got c=%b%b d=%b%b want 0", w,
                         c_rvld[1], c_rvld[2], d_rvld[1], d_rvld[2]);
            end
        end
        @(negedge clk);
        idle();
        c_req = 1'b1;
        d_req = 1'b1;
        #1;
        tests++;
        if (c_gnt[1] !== 1'b1 || d_gnt[1] !== 1'b0) begin
            fails++;
            $display("FAIL rst_first_contention got c=%b d=%b want 1 0", c_gnt[1], d_gnt[1]);
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        test_reset();
        test_c_read();
        test_alternate();
        test_lock_starve();
        test_pipelined_reads();
        test_write_strb();
        test_reset_midread();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
